// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared architectural constants and the fetch FSM state type for the prefetch unit.
package fetch_prefetch_queue_pkg;

  localparam int unsigned    DEF_DEPTH      = 4;
  localparam int unsigned    DEF_ADDR_WIDTH = 32;
  localparam int unsigned    DEF_DATA_WIDTH = 32;
  localparam int unsigned    DEF_PC_STEP    = 1;
  localparam longint unsigned DEF_RESET_PC  = 0;
  localparam longint unsigned NOP_INSTR     = 0;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-side bundle: control in, memory read port 0, and the valid/ready issue port.
interface fetch_prefetch_queue_if
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
);
  localparam int CW = cnt_width(DEPTH);

  logic                  fetch_en;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic [CW-1:0]         occupancy;

  modport master (
    input  fetch_en, redirect, redirect_addr, mem_read_data, instr_ready,
    output mem_read_en, mem_read_addr, instr_valid, instr_out, instr_pc, occupancy
  );

  modport slave (
    output fetch_en, redirect, redirect_addr, mem_read_data, instr_ready,
    input  mem_read_en, mem_read_addr, instr_valid, instr_out, instr_pc, occupancy
  );

endinterface

// File: rtl/fetch_prefetch_queue_fetch_queue.sv
// Synchronous FIFO of {instr, pc}; head is visible combinationally, push/pop take effect at the edge.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module fetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_dat,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_dat     = r_mem[r_rd_ptr[AW-1:0]];
  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetch into a small queue: request-to-instr_valid is 2 cycles.
// Requests are credit-limited by queue occupancy plus the in-flight read; issue backpressure is instr_ready.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int                    DEPTH      = DEF_DEPTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned           PC_STEP    = DEF_PC_STEP,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input logic                    clk,
  input logic                    rst,
  fetch_prefetch_queue_if.master bus
);
  localparam int CW = cnt_width(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  logic                  r_inflight_v;
  logic                  w_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [CW:0]           w_credit_used;
  entry_t                w_head;
  entry_t                w_wr_entry;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BOOT: w_state_nxt = bus.fetch_en ? ST_RUN : ST_HOLD;
      ST_RUN:  if (!bus.fetch_en) w_state_nxt = ST_HOLD;
      ST_HOLD: if (bus.fetch_en)  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
    if (bus.redirect) w_state_nxt = bus.fetch_en ? ST_RUN : ST_HOLD;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_BOOT;
    else      r_state <= w_state_nxt;
  end

  // Occupancy is taken before this cycle's dequeue, so a granted read always has a slot waiting.
  assign w_credit_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight_v};
  assign w_req         = (r_state == ST_RUN) && !bus.redirect && (w_credit_used < (CW+1)'(DEPTH));
  assign w_push        = r_inflight_v && !bus.redirect;
  assign w_valid       = !w_empty && !bus.redirect;
  assign w_pop         = w_valid && bus.instr_ready;
  assign w_wr_entry    = '{instr: bus.mem_read_data, pc: r_inflight_pc};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_v  <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.redirect) begin
      r_fetch_pc   <= bus.redirect_addr;
      r_inflight_v <= 1'b0;
    end else begin
      r_inflight_v <= w_req;
      if (w_req) begin
        r_fetch_pc    <= r_fetch_pc + ADDR_WIDTH'(PC_STEP);
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   (w_wr_entry),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) (w_push && w_full) |-> w_pop);

  assign bus.mem_read_en   = w_req;
  assign bus.mem_read_addr = r_fetch_pc;
  assign bus.instr_valid   = w_valid;
  assign bus.instr_out     = w_empty ? DATA_WIDTH'(NOP_INSTR) : w_head.instr;
  assign bus.instr_pc      = w_empty ? '0 : w_head.pc;
  assign bus.occupancy     = w_count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios plus random traffic against a queue-level model.
module tb_fetch_prefetch_queue;
  import fetch_prefetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] RST_PC = '0;
  localparam logic [AW-1:0] OFS    = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fetch_prefetch_queue #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_STEP(1), .RESET_PC(RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One-cycle-latency memory; cycles without a request return junk.
  always @(posedge clk) bus.mem_read_data <= bus.mem_read_en ? bus.mem_read_addr + OFS : $urandom;

  typedef enum int {M_BOOT, M_RUN, M_HOLD} mstate_t;
  mstate_t       m_state;
  logic [AW-1:0] m_fpc;
  logic [AW-1:0] m_ipc;
  logic          m_infl;
  logic [AW-1:0] q_pc[$];
  logic [AW-1:0] acc_q[$];
  logic [AW-1:0] req_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  logic          exp_en, exp_valid;
  logic [AW-1:0] exp_addr, exp_pc;
  logic [DW-1:0] exp_instr;
  logic [CW-1:0] exp_occ;

  task automatic predict();
    exp_occ   = CW'(q_pc.size());
    exp_en    = (m_state == M_RUN) && !bus.redirect && (q_pc.size() + int'(m_infl) < DEPTH);
    exp_addr  = m_fpc;
    exp_valid = (q_pc.size() > 0) && !bus.redirect;
    exp_pc    = '0;
    exp_instr = '0;
    if (q_pc.size() > 0) begin
      exp_pc    = q_pc[0];
      exp_instr = q_pc[0] + OFS;
    end
  endtask

  task automatic tick();
    predict();
    if (rst && bus.instr_valid && bus.instr_ready) acc_q.push_back(bus.instr_pc);
    if (rst && bus.mem_read_en) req_q.push_back(bus.mem_read_addr);
    if (!rst) begin
      m_state = M_BOOT; m_fpc = RST_PC; m_infl = 1'b0; q_pc.delete();
    end else if (bus.redirect) begin
      q_pc.delete(); m_infl = 1'b0; m_fpc = bus.redirect_addr;
      m_state = bus.fetch_en ? M_RUN : M_HOLD;
    end else begin
      if (exp_valid && bus.instr_ready) void'(q_pc.pop_front());
      if (m_infl) q_pc.push_back(m_ipc);
      m_infl = exp_en;
      if (exp_en) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + AW'(1);
      end
      m_state = bus.fetch_en ? M_RUN : M_HOLD;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.fetch_en = 1'b1; bus.instr_ready = 1'b1;
    bus.redirect = 1'b1; bus.redirect_addr = 32'h55;
    tick();
    tick();
    bus.redirect = 1'b0;
    #1;
    n_tests += 3;
    if (bus.mem_read_en !== 1'b0 || bus.mem_read_addr !== RST_PC) begin
      n_fail++; $display("FAIL reset_req en/addr got %b/%h want 0/%h", bus.mem_read_en, bus.mem_read_addr, RST_PC);
    end
    if (bus.instr_valid !== 1'b0 || bus.occupancy !== '0) begin
      n_fail++; $display("FAIL reset_q vld/occ got %b/%0d want 0/0", bus.instr_valid, bus.occupancy);
    end
    if (bus.instr_out !== '0 || bus.instr_pc !== '0) begin
      n_fail++; $display("FAIL reset_out instr/pc got %h/%h want 0/0", bus.instr_out, bus.instr_pc);
    end
  endtask

  // Entered directly after a reset edge, with the unit in BOOT.
  task automatic test_stream(input string tag);
    int first_en, first_vld;
    bit ok;
    first_en = -1; first_vld = -1; acc_q.delete();
    rst = 1'b1; bus.fetch_en = 1'b1; bus.instr_ready = 1'b1; bus.redirect = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1; predict(); n_tests += 2;
      if ({bus.mem_read_en, bus.mem_read_addr, bus.instr_valid, bus.occupancy} !== {exp_en, exp_addr, exp_valid, exp_occ}) begin
        n_fail++; $display("FAIL %s_ctl i=%0d en/addr/vld/occ got %b/%h/%b/%0d want %b/%h/%b/%0d", tag, i,
          bus.mem_read_en, bus.mem_read_addr, bus.instr_valid, bus.occupancy, exp_en, exp_addr, exp_valid, exp_occ);
      end
      if (bus.instr_out !== exp_instr || (exp_valid && bus.instr_pc !== exp_pc)) begin
        n_fail++; $display("FAIL %s_dat i=%0d instr/pc got %h/%h want %h/%h", tag, i, bus.instr_out, bus.instr_pc, exp_instr, exp_pc);
      end
      if (bus.mem_read_en === 1'b1 && first_en < 0) first_en = i;
      if (bus.instr_valid === 1'b1 && first_vld < 0) first_vld = i;
      tick();
    end
    n_tests += 2;
    if (first_en != 1 || first_vld != 3) begin
      n_fail++; $display("FAIL %s_lat first req/valid cycle got %0d/%0d want 1/3", tag, first_en, first_vld);
    end
    ok = (acc_q.size() == 9);
    foreach (acc_q[k]) if (acc_q[k] !== AW'(k)) ok = 0;
    if (!ok) begin
      n_fail++; $display("FAIL %s_seq accepted %0d pcs (first %h) want 9 pcs 0..8", tag, acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : '1);
    end
  endtask

  task automatic test_stall();
    bit ok;
    rst = 1'b0; tick();
    rst = 1'b1; bus.fetch_en = 1'b1; bus.instr_ready = 1'b0; acc_q.delete(); req_q.delete();
    for (int i = 0; i < 22; i++) begin
      if (i == 12) bus.instr_ready = 1'b1;
      #1; predict(); n_tests++;
      if ({bus.mem_read_en, bus.mem_read_addr, bus.instr_valid, bus.occupancy, bus.instr_out} !== {exp_en, exp_addr, exp_valid, exp_occ, exp_instr}) begin
        n_fail++; $display("FAIL stall_ctl i=%0d en/addr/vld/occ/instr got %b/%h/%b/%0d/%h want %b/%h/%b/%0d/%h", i,
          bus.mem_read_en, bus.mem_read_addr, bus.instr_valid, bus.occupancy, bus.instr_out, exp_en, exp_addr, exp_valid, exp_occ, exp_instr);
      end
      if (i == 11) begin
        n_tests += 2;
        ok = (req_q.size() == 4);
        foreach (req_q[k]) if (req_q[k] !== AW'(k)) ok = 0;
        if (!ok) begin
          n_fail++; $display("FAIL stall_reqs got %0d requests want 4 (addr 0..3)", req_q.size());
        end
        if (bus.occupancy !== CW'(4) || bus.mem_read_en !== 1'b0) begin
          n_fail++; $display("FAIL stall_full occ/en got %0d/%b want 4/0", bus.occupancy, bus.mem_read_en);
        end
      end
      tick();
    end
    n_tests++;
    ok = (acc_q.size() == 10);
    foreach (acc_q[k]) if (acc_q[k] !== AW'(k)) ok = 0;
    if (!ok) begin
      n_fail++; $display("FAIL stall_drain accepted %0d pcs want 10 (pc 0..9, one per cycle)", acc_q.size());
    end
  endtask

  task automatic test_redirect();
    bit found, ok;
    rst = 1'b0; tick();
    rst = 1'b1; bus.fetch_en = 1'b1; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_infl && m_ipc == AW'(5) && q_pc.size() == 2) found = 1;
      else begin
        bus.instr_ready = (q_pc.size() >= 2);
        #1; predict(); n_tests++;
        if ({bus.mem_read_en, bus.mem_read_addr, bus.occupancy} !== {exp_en, exp_addr, exp_occ}) begin
          n_fail++; $display("FAIL redir_setup i=%0d en/addr/occ got %b/%h/%0d want %b/%h/%0d", i,
            bus.mem_read_en, bus.mem_read_addr, bus.occupancy, exp_en, exp_addr, exp_occ);
        end
        tick();
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL redir_setup_timeout got no cycle with addr 5 in flight and 2 queued, want one");
    end
    bus.redirect = 1'b1; bus.redirect_addr = 32'h40; bus.instr_ready = 1'b1;
    #1; n_tests++;
    if (bus.instr_valid !== 1'b0 || bus.mem_read_en !== 1'b0) begin
      n_fail++; $display("FAIL redir_cycle vld/en got %b/%b want 0/0", bus.instr_valid, bus.mem_read_en);
    end
    acc_q.delete();
    tick();
    bus.redirect = 1'b0;
    #1; n_tests += 2;
    if (bus.occupancy !== '0) begin
      n_fail++; $display("FAIL redir_flush occ got %0d want 0", bus.occupancy);
    end
    if (bus.mem_read_en !== 1'b1 || bus.mem_read_addr !== 32'h40) begin
      n_fail++; $display("FAIL redir_target en/addr got %b/%h want 1/00000040", bus.mem_read_en, bus.mem_read_addr);
    end
    for (int i = 0; i < 8; i++) begin
      #1; predict(); n_tests++;
      if ({bus.instr_valid, bus.instr_out} !== {exp_valid, exp_instr} || (exp_valid && bus.instr_pc !== exp_pc)) begin
        n_fail++; $display("FAIL redir_post i=%0d vld/instr/pc got %b/%h/%h want %b/%h/%h", i,
          bus.instr_valid, bus.instr_out, bus.instr_pc, exp_valid, exp_instr, exp_pc);
      end
      tick();
    end
    n_tests++;
    ok = (acc_q.size() == 6);
    foreach (acc_q[k]) if (acc_q[k] !== 32'h40 + AW'(k)) ok = 0;
    if (!ok) begin
      n_fail++; $display("FAIL redir_seq accepted %0d pcs (first %h) want 6 pcs from 00000040", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : '1);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    bus.redirect = 1'b1; bus.redirect_addr = 32'hFFFF_FFFE; bus.fetch_en = 1'b1; bus.instr_ready = 1'b1;
    tick();
    bus.redirect = 1'b0; acc_q.delete();
    for (int i = 0; i < 7; i++) tick();
    n_tests++;
    ok = (acc_q.size() == 5);
    foreach (acc_q[k]) if (acc_q[k] !== 32'hFFFF_FFFE + AW'(k)) ok = 0;
    if (!ok) begin
      n_fail++; $display("FAIL wrap_seq accepted %0d pcs (first %h) want fffffffe,ffffffff,0,1,2", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : '0);
    end
  endtask

  task automatic test_hold();
    int hold_req;
    bit ok;
    rst = 1'b0; tick();
    rst = 1'b1; bus.instr_ready = 1'b1; hold_req = 0; acc_q.delete(); req_q.delete();
    for (int i = 0; i < 20; i++) begin
      bus.fetch_en = !(i >= 6 && i < 9);
      #1; predict(); n_tests++;
      if ({bus.mem_read_en, bus.mem_read_addr, bus.instr_valid, bus.instr_out} !== {exp_en, exp_addr, exp_valid, exp_instr}) begin
        n_fail++; $display("FAIL hold_ctl i=%0d en/addr/vld/instr got %b/%h/%b/%h want %b/%h/%b/%h", i,
          bus.mem_read_en, bus.mem_read_addr, bus.instr_valid, bus.instr_out, exp_en, exp_addr, exp_valid, exp_instr);
      end
      if (i >= 7 && i <= 9 && bus.mem_read_en !== 1'b0) hold_req++;
      tick();
    end
    n_tests += 2;
    if (hold_req != 0) begin
      n_fail++; $display("FAIL hold_noreq got %0d requests in HOLD want 0", hold_req);
    end
    ok = (req_q.size() == 16) && (acc_q.size() == 14);
    foreach (req_q[k]) if (req_q[k] !== AW'(k)) ok = 0;
    foreach (acc_q[k]) if (acc_q[k] !== AW'(k)) ok = 0;
    if (!ok) begin
      n_fail++; $display("FAIL hold_seq got %0d reqs/%0d accepts want 16/14, both contiguous from 0", req_q.size(), acc_q.size());
    end
  endtask

  // Fills the queue, then resets with a redirect also asserted; reset must win.
  task automatic test_reset_mid();
    bus.fetch_en = 1'b1; bus.instr_ready = 1'b0; rst = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    #1; n_tests++;
    if (bus.occupancy !== CW'(DEPTH)) begin
      n_fail++; $display("FAIL rstmid_full occ got %0d want %0d", bus.occupancy, DEPTH);
    end
    rst = 1'b0; bus.redirect = 1'b1; bus.redirect_addr = 32'h77; bus.instr_ready = 1'b1;
    tick();
    bus.redirect = 1'b0;
    #1; n_tests++;
    if ({bus.occupancy, bus.instr_valid, bus.mem_read_en, bus.mem_read_addr} !== {CW'(0), 1'b0, 1'b0, RST_PC}) begin
      n_fail++; $display("FAIL rstmid_state occ/vld/en/addr got %0d/%b/%b/%h want 0/0/0/%h",
        bus.occupancy, bus.instr_valid, bus.mem_read_en, bus.mem_read_addr, RST_PC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst               = ($urandom_range(0, 63) != 0);
      bus.fetch_en      = ($urandom_range(0, 7) != 0);
      bus.instr_ready   = ($urandom_range(0, 2) != 0);
      bus.redirect      = ($urandom_range(0, 15) == 0);
      bus.redirect_addr = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFE : AW'($urandom);
      #1; predict(); n_tests++;
      if ({bus.mem_read_en, bus.mem_read_addr, bus.instr_valid, bus.occupancy, bus.instr_out} !== {exp_en, exp_addr, exp_valid, exp_occ, exp_instr}
          || (exp_valid && bus.instr_pc !== exp_pc)) begin
        n_fail++; $display("FAIL rand i=%0d en/addr/vld/occ/instr/pc got %b/%h/%b/%0d/%h/%h want %b/%h/%b/%0d/%h/%h", i,
          bus.mem_read_en, bus.mem_read_addr, bus.instr_valid, bus.occupancy, bus.instr_out, bus.instr_pc,
          exp_en, exp_addr, exp_valid, exp_occ, exp_instr, exp_pc);
      end
      tick();
    end
    bus.redirect = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    bus.fetch_en = 1'b0; bus.redirect = 1'b0; bus.redirect_addr = '0; bus.instr_ready = 1'b0;
    test_reset();
    test_stream("stream");
    test_stall();
    test_redirect();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_stream("restart");
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Instruction prefetch unit. It sits directly upstream of the issue register and replaces the bare PC-to-memory path.
- Generates sequential instruction-fetch addresses into main-memory read port 0, which has a fixed 1-cycle read latency.
- Buffers returned words with their PCs in a small FIFO and presents them to issue with a valid/ready handshake.
- On a taken-jump redirect, flushes the FIFO and any in-flight read, then restarts fetching from the target.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ADDR_WIDTH, 32, PC / memory address width
DATA_WIDTH, 32, instruction width
PC_STEP, 1, address increment per sequential fetch
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-low reset
fetch_en  input  1  1 = fetching allowed; 0 = no new memory reads
redirect  input  1  taken jump; flush and restart
redirect_addr  input  ADDR_WIDTH  jump target
mem_read_en  output  1  read request this cycle
mem_read_addr  output  ADDR_WIDTH  read address
mem_read_data  input  DATA_WIDTH  data for the request issued in the previous cycle
instr_valid  output  1  head entry available
instr_ready  input  1  issue accepts the head entry (= not stall)
instr_out  output  DATA_WIDTH  head instruction
instr_pc  output  ADDR_WIDTH  PC of head instruction
occupancy  output  log2(DEPTH)+1  entries held (debug)

Interface (already decided): one clock; reset is synchronous and active-low (clk, rst).

Behaviour:
- Reset (rst=0 at a clock edge):
  - fetch_pc=RESET_PC; FIFO empty; inflight_v=0; state=BOOT.
  - Outputs: mem_read_en=0, mem_read_addr=RESET_PC, instr_valid=0, instr_out=0 (NOP), instr_pc=0, occupancy=0.
  - Reset wins over every other input.
- FSM states:
  - BOOT: exactly one cycle after reset, no request. Goes to RUN if fetch_en=1, else HOLD.
  - RUN: request when the credit rule allows. Goes to HOLD when fetch_en=0.
  - HOLD: no new requests. An in-flight response is still captured. Goes back to RUN when fetch_en=1.
  - redirect from any state except reset: next state is RUN if fetch_en=1, else HOLD.
- Credit rule: mem_read_en = (state==RUN) && !redirect && (occupancy + inflight_v + ...
  - Precise form: mem_read_en = (state==RUN) && !redirect && (occupancy + inflight_v < DEPTH).
  - Occupancy is the value before this cycle's dequeue. The FIFO therefore never overflows, and a response is never dropped for lack of space.
- Request: mem_read_addr = fetch_pc (combinational). When mem_read_en=1: fetch_pc <= fetch_pc + PC_STEP, wrapping modulo 2^ADDR_WIDTH; inflight_v <= 1; inflight_pc <= fetch_pc.
- Response:
  - If inflight_v=1 and no redirect this cycle, push {mem_read_data, inflight_pc} at the edge.
  - inflight_v clears unless a new request is issued in the same cycle.
- Output timing: instr_valid = !empty && !redirect.
  - instr_out and instr_pc come from the head entry, with no bypass. Latency from request to instr_valid is 2 cycles.
  - When the FIFO is empty, instr_out=0 (NOP).
- Dequeue: occurs on instr_valid && instr_ready.
- Simultaneous push and pop: both happen, and occupancy is unchanged.
- Redirect (takes effect at the edge):
  - FIFO emptied; inflight_v=0, so the stale response is discarded; fetch_pc=redirect_addr.
  - Redirect wins over push, pop and request in that cycle. First request to the target is the following cycle.
- Pointers: read and write pointers are log2(DEPTH)+1 bits. full = MSBs differ and the rest match; empty = pointers equal. Wrap is natural.
- Both instr_pc and fetch_pc wrap at address 2^ADDR_WIDTH-1.

Decomposition:
- Shared arch package: RESET_PC default, NOP_INSTR = 0, PC_STEP.
- Sub-module fetch_queue: synchronous FIFO of {instr, pc}. Inputs push, pop, flush; outputs full, empty, count.
- fetch_prefetch_queue holds the FSM, PC, credit and in-flight logic.

Test Plan:
1. Reset, then fetch_en=1, ready=1, memory returns word=addr+0x100 -> mem_read_en first high 1 cycle after reset release with addr 0; first instr_valid 2 cycles later, pc=0, instr=0x100; one instruction per cycle thereafter, pcs 0,1,2,...
2. ready=0 held -> exactly 4 requests (addr 0..3); occupancy=4; mem_read_en stays 0; raise ready -> pcs 0..3 drain, then fetching resumes at 4 with no gap beyond 2 cycles.
3. redirect=1, redirect_addr=0x40 while a read of addr 5 is in flight and FIFO holds 2 entries -> instr_valid=0 that cycle; the addr-5 data never appears; next cycle mem_read_addr=0x40; first valid pc=0x40.
4. redirect and instr_ready=1 in the same cycle with FIFO non-empty -> no dequeue handshake counted; occupancy=0 after the edge.
5. fetch_en dropped for 3 cycles mid-stream -> in-flight word still enqueued; no requests during HOLD; resumes with the next sequential pc, with no duplicate or skipped pc.
6. rst=0 mid-operation with FIFO full -> next cycle occupancy=0, instr_valid=0, mem_read_addr=RESET_PC; the sequence restarts exactly as in scenario 1.
